// File: rtl/pwm_fade_ctrl.sv
// Duty-ramp sequencer for a free-running R-bit PWM generator.
// It steps o_duty toward a latched target and changes it only at PWM period boundaries.
module pwm_fade_ctrl #(
  parameter int R = 4,
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_start,
  input  logic [R-1:0] i_target,
  input  logic [R-1:0] i_step,
  input  logic [W-1:0] i_interval,
  input  logic         i_abort,
  output logic [R-1:0] o_duty,
  output logic         o_period_end,
  output logic         o_busy,
  output logic         o_done
);

  typedef enum logic {IDLE, RAMP} state_e;

  state_e         state_q, state_d;
  logic [R-1:0]   phase_q;
  logic [W-1:0]   intCnt_q, intCnt_d;
  logic [R-1:0]   duty_q, duty_d;
  logic [R-1:0]   target_q, target_d;
  logic [R-1:0]   step_q, step_d;
  logic [W-1:0]   interval_q, interval_d;
  logic           done_q, done_d;

  logic [R:0]     dutyExt, targetExt, stepExt, sumUp, diffDn, nextDuty;
  logic           periodEnd;

  assign periodEnd    = (phase_q == '1);
  assign o_period_end = periodEnd;
  assign o_duty       = duty_q;
  assign o_busy       = (state_q == RAMP);
  assign o_done       = done_q;

  // One step toward the target, computed one bit wider so it saturates instead of wrapping.
  always_comb begin
    dutyExt   = {1'b0, duty_q};
    targetExt = {1'b0, target_q};
    stepExt   = {1'b0, step_q};
    sumUp     = dutyExt + stepExt;
    diffDn    = dutyExt - stepExt;
    nextDuty  = targetExt;
    if (duty_q < target_q) begin
      nextDuty = (sumUp > targetExt) ? targetExt : sumUp;
    end else if ((stepExt <= dutyExt) && (diffDn > targetExt)) begin
      nextDuty = diffDn;
    end
  end

  always_comb begin
    state_d    = state_q;
    intCnt_d   = intCnt_q;
    duty_d     = duty_q;
    target_d   = target_q;
    step_d     = step_q;
    interval_d = interval_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start && !i_abort) begin
          target_d   = i_target;
          step_d     = (i_step == '0) ? R'(1) : i_step;
          interval_d = (i_interval == '0) ? W'(1) : i_interval;
          intCnt_d   = '0;
          state_d    = RAMP;
        end
      end
      RAMP: begin
        if (i_abort) begin
          state_d  = IDLE;
          intCnt_d = '0;
        end else if (duty_q == target_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (periodEnd) begin
          // The period running at start counts as a full interval period.
          if (intCnt_q == interval_q - W'(1)) begin
            duty_d   = nextDuty[R-1:0];
            intCnt_d = '0;
          end else begin
            intCnt_d = intCnt_q + W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      phase_q    <= '0;
      intCnt_q   <= '0;
      duty_q     <= '0;
      target_q   <= '0;
      step_q     <= '0;
      interval_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_q + R'(1);
      intCnt_q   <= intCnt_d;
      duty_q     <= duty_d;
      target_q   <= target_d;
      step_q     <= step_d;
      interval_q <= interval_d;
      done_q     <= done_d;
    end
  end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Bench for pwm_fade_ctrl: directed ramps plus random traffic against a schedule-based model.
module tb_pwm_fade_ctrl;
  localparam int R   = 4;
  localparam int W   = 8;
  localparam int PER = 1 << R;

  typedef struct {
    int edgeNo;
    int duty;
  } ev_t;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic         i_start = 1'b0;
  logic         i_abort = 1'b0;
  logic [R-1:0] i_target = '0;
  logic [R-1:0] i_step = '0;
  logic [W-1:0] i_interval = '0;
  logic [R-1:0] o_duty;
  logic         o_period_end;
  logic         o_busy;
  logic         o_done;

  int  checks = 0;
  int  errors = 0;
  int  mDuty = 0;
  int  mTarget = 0;
  int  compEdge = 0;
  int  edgeIdx = 0;
  bit  mBusy = 1'b0;
  bit  mDone = 1'b0;
  ev_t schedQ[$];
  int  prevDuty = 0;
  bit  prevPe = 1'b0;
  bit  lastEdgeReset = 1'b1;

  pwm_fade_ctrl #(.R(R), .W(W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_target(i_target),
    .i_step(i_step), .i_interval(i_interval), .i_abort(i_abort),
    .o_duty(o_duty), .o_period_end(o_period_end), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  function automatic int stepToward(int d, int t, int s);
    int n;
    if (d < t) begin
      n = d + s;
      return (n > t) ? t : n;
    end
    n = d - s;
    return (n < t) ? t : n;
  endfunction

  // Builds the full list of duty updates for an accepted start at edge e.
  task automatic buildSchedule(input int e);
    int t, s, iv, d, pe, k, last;
    ev_t ev;
    t  = int'(i_target);
    s  = (i_step == '0) ? 1 : int'(i_step);
    iv = (i_interval == '0) ? 1 : int'(i_interval);
    mTarget = t;
    d  = mDuty;
    pe = e + 1;
    while ((pe % PER) != PER - 1) pe++;
    k = 1;
    last = e;
    schedQ.delete();
    while (d != t) begin
      d = stepToward(d, t, s);
      last = pe + PER * (iv * k - 1);
      ev.edgeNo = last;
      ev.duty = d;
      schedQ.push_back(ev);
      k++;
    end
    compEdge = last + 1;
    mBusy = 1'b1;
  endtask

  task automatic modelEdge();
    int e;
    if (!i_rst_n) begin
      mDuty = 0; mTarget = 0; mBusy = 1'b0; mDone = 1'b0;
      schedQ.delete();
      edgeIdx = 0;
      return;
    end
    e = edgeIdx;
    mDone = 1'b0;
    if (mBusy) begin
      if (i_abort) begin
        mBusy = 1'b0;
        schedQ.delete();
      end else if (schedQ.size() == 0 && e == compEdge) begin
        mBusy = 1'b0;
        mDone = 1'b1;
      end else if (schedQ.size() > 0 && schedQ[0].edgeNo == e) begin
        mDuty = schedQ[0].duty;
        void'(schedQ.pop_front());
      end
    end else if (i_start && !i_abort) begin
      buildSchedule(e);
    end
    edgeIdx++;
  endtask

  task automatic checkOutput(input string tag);
    bit expPe;
    expPe = ((edgeIdx % PER) == PER - 1);
    checks++;
    assert (o_duty === R'(mDuty)) else begin
      errors++;
      $error("FAIL %s duty observed %0d expected %0d", tag, o_duty, mDuty);
    end
    checks++;
    assert (o_busy === mBusy) else begin
      errors++;
      $error("FAIL %s busy observed %0b expected %0b", tag, o_busy, mBusy);
    end
    checks++;
    assert (o_done === mDone) else begin
      errors++;
      $error("FAIL %s done observed %0b expected %0b", tag, o_done, mDone);
    end
    checks++;
    assert (o_period_end === expPe) else begin
      errors++;
      $error("FAIL %s period_end observed %0b expected %0b", tag, o_period_end, expPe);
    end
    checks++;
    assert (int'(o_duty) == prevDuty || prevPe || lastEdgeReset) else begin
      errors++;
      $error("FAIL %s duty_off_boundary observed %0d expected %0d", tag, o_duty, prevDuty);
    end
    checks++;
    assert (!(o_done && o_busy)) else begin
      errors++;
      $error("FAIL %s done_and_busy observed 1 expected 0", tag);
    end
    prevDuty = int'(o_duty);
    prevPe = expPe;
  endtask

  task automatic applyStimulus(input bit rstn, input bit start, input bit abort,
                               input int target, input int step, input int interval);
    i_rst_n    = rstn;
    i_start    = start;
    i_abort    = abort;
    i_target   = R'(target);
    i_step     = R'(step);
    i_interval = W'(interval);
  endtask

  task automatic clockCycle(input string tag);
    @(posedge i_clk);
    lastEdgeReset = !i_rst_n;
    modelEdge();
    @(negedge i_clk);
    checkOutput(tag);
  endtask

  task automatic idleCycles(input int n, input string tag);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0);
    for (int i = 0; i < n; i++) clockCycle(tag);
  endtask

  task automatic startRamp(input int target, input int step, input int interval, input string tag);
    applyStimulus(1'b1, 1'b1, 1'b0, target, step, interval);
    clockCycle(tag);
    applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0);
  endtask

  initial begin
    int guard;
    $display("[TB] reset");
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
    for (int i = 0; i < 3; i++) clockCycle("reset");
    idleCycles(20, "post_reset");

    $display("[TB] ramp up 0->12 step 5 interval 2");
    startRamp(12, 5, 2, "up_start");
    idleCycles(120, "ramp_up");

    $display("[TB] ramp down 12->1 step 4 interval 1");
    startRamp(1, 4, 1, "down_start");
    idleCycles(70, "ramp_down");

    $display("[TB] reset mid-ramp");
    startRamp(9, 1, 1, "rst_ramp_start");
    idleCycles(40, "rst_ramp");
    applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0);
    for (int i = 0; i < 2; i++) clockCycle("mid_reset");
    idleCycles(20, "after_mid_reset");

    $display("[TB] zero step and interval");
    startRamp(3, 0, 0, "zero_start");
    idleCycles(70, "zero_fields");

    $display("[TB] abort at duty 6");
    startRamp(15, 1, 1, "abort_start");
    guard = 0;
    while (mDuty != 6 && guard < 400) begin
      clockCycle("abort_ramp");
      guard++;
    end
    checks++;
    assert (o_duty === R'(6)) else begin
      errors++;
      $error("FAIL abort_reach observed %0d expected 6", o_duty);
    end
    applyStimulus(1'b1, 1'b1, 1'b1, 2, 1, 1);
    clockCycle("abort_edge");
    idleCycles(40, "after_abort");
    startRamp(6, 1, 1, "same_target");
    idleCycles(5, "same_target_done");

    $display("[TB] start ignored while busy");
    startRamp(9, 1, 1, "busy_start");
    idleCycles(10, "busy_ramp");
    applyStimulus(1'b1, 1'b1, 1'b0, 2, 3, 1);
    clockCycle("busy_restart");
    idleCycles(80, "busy_finish");

    $display("[TB] random traffic");
    for (int i = 0; i < 4000; i++) begin
      applyStimulus($urandom_range(0, 999) != 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 79) == 0, int'($urandom_range(0, PER - 1)),
                    int'($urandom_range(0, PER - 1)), int'($urandom_range(0, 3)));
      clockCycle("random");
    end
    idleCycles(5, "final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
